// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential 32-bit restoring divider controller (DIV/DIVU).
// It steps one shared external adder through 32 restoring-division cycles.
// The same adder then applies sign correction to the quotient and/or the
// remainder.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, is_signed      request (sampled only in IDLE), 1 = DIV / 0 = DIVU
//   dividend, divisor     operands, sampled on the accepting edge
//   busy, done            busy while not IDLE; done is a one-cycle result pulse
//   quotient, remainder   registered results (LO / HI)
//   add_a, add_b, add_cin shared adder operands, combinational from state/regs
//   add_r, add_cout       shared adder sum and carry-out
module div_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_r,
  input  logic        add_cout
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_NEG_Q = 3'd2,
    S_NEG_R = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   dq_q, dq_d;     // dividend shifting out, quotient shifting in
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rmd_q, rmd_d;

  logic [W-1:0]   shifted;
  logic           ok;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  // Next-state, datapath and adder operand selection.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    shifted = '0;
    ok      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sq_d  = is_signed & (dividend[W-1] ^ divisor[W-1]);
          sr_d  = is_signed & dividend[W-1];
          rem_d = '0;
          cnt_d = CW'(W - 1);
          if (divisor == '0) begin
            // Divide by zero bypasses the loop; results are fixed.
            dq_d    = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else begin
            dq_d    = (is_signed && dividend[W-1]) ? W'(~dividend + W'(1)) : dividend;
            dvs_d   = (is_signed && divisor[W-1])  ? W'(~divisor + W'(1))  : divisor;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        shifted = {rem_q[W-2:0], dq_q[W-1]};
        add_a   = shifted;
        add_b   = ~dvs_q;
        add_cin = 1'b1;
        // rem_q[W-1] means the shifted value has a 33rd bit, so it exceeds dvs.
        ok      = add_cout | rem_q[W-1];
        rem_d   = ok ? add_r : shifted;
        dq_d    = {dq_q[W-2:0], ok};
        if (cnt_q == '0) begin
          if (sq_q)      state_d = S_NEG_Q;
          else if (sr_q) state_d = S_NEG_R;
          else           state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_NEG_Q: begin
        add_a   = ~dq_q;
        add_cin = 1'b1;
        dq_d    = add_r;
        state_d = sr_q ? S_NEG_R : S_DONE;
      end

      S_NEG_R: begin
        add_a   = ~rem_q;
        add_cin = 1'b1;
        rem_d   = add_r;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result registers load on entry to DONE and hold otherwise.
  always_comb begin
    quo_d = quo_q;
    rmd_d = rmd_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      quo_d = dq_d;
      rmd_d = rem_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench for div_seq_ctrl with a behavioural 32-bit adder.
module tb_div_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_r;
  logic        add_cout;
  logic [32:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  div_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_r     (add_r),
    .add_cout  (add_cout)
  );

  // External shared adder.
  assign sum      = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_r    = sum[31:0];
  assign add_cout = sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input int exp_lat, input int poke);
    int k;
    int bad_busy;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'b0;
    k         = 1;
    bad_busy  = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) bad_busy++;
      if (k == poke) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd5;
        divisor   = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " busy_hold"}, 32'(bad_busy), 32'd0);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " add_a_done"}, add_a, 32'd0);
    // start during the done cycle must be ignored
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " q_held"}, quotient, exp_q);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst add_a", add_a, 32'd0);
    check("rst add_b", add_b, 32'd0);
    check("rst add_cin", {31'd0, add_cin}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 0);
    run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   35, 0);
    run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34, 0);
    run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33, 0);
    run_op("divu_ovf",    1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33, 0);
    run_op("div_by0",     1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1,  0);
    run_op("divu_by0",    1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1,  0);
    run_op("div_neg_by0", 1'b1, 32'h87654321,   32'd0,          32'hFFFFFFFF,   32'h87654321,   1,  0);
    run_op("div_intmin",  1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34, 10);
    run_op("div_m100_7",  1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   35, 0);
    run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   34, 0);
    run_op("div_100_7",   1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33, 0);

    // Reset mid-operation: abort with no done pulse.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst busy", {31'd0, busy}, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    check("mid_rst quotient", quotient, 32'd0);
    check("mid_rst remainder", remainder, 32'd0);
    reset = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) seen_done++;
      end
      check("mid_rst no_done", 32'(seen_done), 32'd0);
    end

    run_op("after_rst",   1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
